// File: rtl/cla_pkg.sv
// ---------------------------------------------------------------------------
// cla_pkg
//   Shared constants and elaboration helpers for the pipelined carry-lookahead
//   adder.
//   Contents:
//     GROUP_W      width of one carry-lookahead group (bits)
//     clog2()      ceiling log2 for sizing index fields
//     stage_count  pipeline depth for a given operand width and groups/stage
// ---------------------------------------------------------------------------
package cla_pkg;

    localparam int GROUP_W = 4;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    function automatic int stage_count(input int width, input int gps);
        return width / (GROUP_W * gps);
    endfunction

endpackage : cla_pkg

// File: rtl/cla_pipe_adder_group4.sv
// ---------------------------------------------------------------------------
// cla_group4
//   Combinational 4-bit carry-lookahead group. Every internal carry is a
//   flat sum of products of generate/propagate terms, so no carry ripples
//   through the group.
//   Ports:
//     a, b    [3:0]  operand bits of this group
//     c_in           carry into bit 0 of the group
//     s       [3:0]  sum bits
//     c_out          carry out of bit 3
//     p_grp          group propagate (AND of bit propagates)
//     g_grp          group generate
//     c_msb          carry into bit 3 (used for signed overflow at the top)
// ---------------------------------------------------------------------------
module cla_group4
    import cla_pkg::*;
(
    input  logic [GROUP_W-1:0] a,
    input  logic [GROUP_W-1:0] b,
    input  logic               c_in,
    output logic [GROUP_W-1:0] s,
    output logic               c_out,
    output logic               p_grp,
    output logic               g_grp,
    output logic               c_msb
);

    logic [GROUP_W-1:0] w_p;
    logic [GROUP_W-1:0] w_g;
    logic [GROUP_W-1:0] w_c;

    assign w_p = a ^ b;
    assign w_g = a & b;

    // Each carry is expanded directly from c_in rather than from the previous
    // carry so the depth stays two levels regardless of bit position.
    assign w_c[0] = c_in;
    assign w_c[1] = w_g[0] | (w_p[0] & c_in);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & c_in);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & c_in);

    assign p_grp = &w_p;
    assign g_grp = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                 | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

    assign s     = w_p ^ w_c;
    assign c_out = g_grp | (p_grp & c_in);
    assign c_msb = w_c[3];

endmodule : cla_group4

// File: rtl/cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// cla_pipe_adder
//   Pipelined adder/subtractor built from 4-bit carry-lookahead groups.
//   Stage k resolves groups k*GPS .. (k+1)*GPS-1 and hands its slice carry to
//   stage k+1 through a register. Valid/ready on both sides; empty stages
//   always load so bubbles collapse, and in_ready is combinational from
//   out_ready through the advance chain.
//   Parameters:
//     WIDTH  operand/result width, multiple of 4*GPS
//     GPS    4-bit groups resolved per stage
//   Ports:
//     clk, rst             clock, asynchronous active-high reset
//     in_valid / in_ready  operand handshake
//     a, b, cin, sub       operands; sub=1 computes a-b and ignores cin
//     out_valid/out_ready  result handshake
//     sum, cout, ovf       result, unsigned carry out, signed overflow
// ---------------------------------------------------------------------------
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GPS   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SLICE_W = GROUP_W * GPS;
    localparam int STAGES  = stage_count(WIDTH, GPS);

    if ((GPS < 1) || (WIDTH % SLICE_W != 0)) begin : g_param_check
        $error("cla_pipe_adder: WIDTH (%0d) must be a multiple of 4*GPS (%0d)",
               WIDTH, SLICE_W);
    end

    // Per-stage registers: operands travel with the partial sum so later
    // stages can finish the upper slices.
    logic [WIDTH-1:0]  r_a [STAGES];
    logic [WIDTH-1:0]  r_b [STAGES];
    logic [WIDTH-1:0]  r_s [STAGES];
    logic [STAGES-1:0] r_v;
    logic [STAGES-1:0] r_c;
    logic [STAGES-1:0] r_sub;
    logic              r_ovf;

    // Values each stage would capture this cycle.
    logic [WIDTH-1:0]  w_a_nx [STAGES];
    logic [WIDTH-1:0]  w_b_nx [STAGES];
    logic [WIDTH-1:0]  w_s_nx [STAGES];
    logic [STAGES-1:0] w_v_in;
    logic [STAGES-1:0] w_c_nx;
    logic [STAGES-1:0] w_sub_nx;
    logic              w_ovf_nx;

    logic [STAGES-1:0] w_adv;
    logic [STAGES-1:0] w_load;

    // Advance chain, evaluated from the output backwards: a stage moves on
    // when it holds a beat and its successor is empty or itself moving.
    // NOTE: every combinational output gets a default before the loop so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_adv = '0;
        w_adv[STAGES-1] = r_v[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_adv[k] = r_v[k] & (~r_v[k+1] | w_adv[k+1]);
        end
    end

    assign w_load   = ~r_v | w_adv;
    assign in_ready = w_load[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0]   w_a_in;
        logic [WIDTH-1:0]   w_b_in;
        logic [WIDTH-1:0]   w_s_in;
        logic               w_c_in;
        logic               w_sub_in;
        logic [GPS-1:0]     w_gp;
        logic [GPS-1:0]     w_gg;
        logic [GPS-1:0]     w_cg;
        logic [GPS-1:0]     w_cout;
        logic [GPS-1:0]     w_cmsb;
        logic [SLICE_W-1:0] w_slice;
        logic [WIDTH-1:0]   w_s_merge;
        logic               w_acc;
        logic               w_term;
        logic               w_unused_grp;

        if (k == 0) begin : g_first
            // Subtraction is a + ~b + 1; the inversion is captured here so
            // later stages never need to look at sub.
            assign w_a_in    = a;
            assign w_b_in    = sub ? ~b : b;
            assign w_s_in    = '0;
            assign w_c_in    = sub | cin;
            assign w_sub_in  = sub;
            assign w_v_in[k] = in_valid;
        end else begin : g_next
            assign w_a_in    = r_a[k-1];
            assign w_b_in    = r_b[k-1];
            assign w_s_in    = r_s[k-1];
            assign w_c_in    = r_c[k-1];
            assign w_sub_in  = r_sub[k-1];
            assign w_v_in[k] = r_v[k-1];
        end

        // Group-level lookahead: carry into group j is
        // G[j-1] | P[j-1]G[j-2] | ... | P[j-1..0]c_in, fully expanded.
        always_comb begin
            w_cg   = '0;
            w_acc  = 1'b0;
            w_term = 1'b0;
            w_cg[0] = w_c_in;
            for (int j = 1; j < GPS; j++) begin
                w_acc = w_c_in;
                for (int i = 0; i < j; i++) begin
                    w_acc = w_acc & w_gp[i];
                end
                for (int i = 0; i < j; i++) begin
                    w_term = w_gg[i];
                    for (int m = i + 1; m < j; m++) begin
                        w_term = w_term & w_gp[m];
                    end
                    w_acc = w_acc | w_term;
                end
                w_cg[j] = w_acc;
            end
        end

        for (genvar j = 0; j < GPS; j++) begin : g_grp
            cla_group4 u_grp (
                .a     (w_a_in[(k*GPS + j)*GROUP_W +: GROUP_W]),
                .b     (w_b_in[(k*GPS + j)*GROUP_W +: GROUP_W]),
                .c_in  (w_cg[j]),
                .s     (w_slice[j*GROUP_W +: GROUP_W]),
                .c_out (w_cout[j]),
                .p_grp (w_gp[j]),
                .g_grp (w_gg[j]),
                .c_msb (w_cmsb[j])
            );
        end

        always_comb begin
            w_s_merge = w_s_in;
            w_s_merge[k*SLICE_W +: SLICE_W] = w_slice;
        end

        assign w_a_nx[k]   = w_a_in;
        assign w_b_nx[k]   = w_b_in;
        assign w_s_nx[k]   = w_s_merge;
        assign w_c_nx[k]   = w_cout[GPS-1];
        assign w_sub_nx[k] = w_sub_in;

        // Only the top group of the last stage feeds overflow; lower group
        // carry-outs are already folded into the lookahead terms.
        assign w_unused_grp = ^{w_cout, w_cmsb};

        if (k == STAGES - 1) begin : g_ovf
            assign w_ovf_nx = w_cmsb[GPS-1] ^ w_cout[GPS-1];
        end
    end

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its predecessor's pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the data arrays are reset along with the valid bits so
            // sum/cout/ovf read 0 after reset instead of stale operands.
            r_v   <= '0;
            r_c   <= '0;
            r_sub <= '0;
            r_ovf <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= '0;
                r_b[k] <= '0;
                r_s[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_load[k]) begin
                    r_v[k] <= w_v_in[k];
                    // Bubbles move the valid bit only; data holds.
                    if (w_v_in[k]) begin
                        r_a[k]   <= w_a_nx[k];
                        r_b[k]   <= w_b_nx[k];
                        r_s[k]   <= w_s_nx[k];
                        r_c[k]   <= w_c_nx[k];
                        r_sub[k] <= w_sub_nx[k];
                    end
                end
            end
            if (w_load[STAGES-1] && w_v_in[STAGES-1]) begin
                r_ovf <= w_ovf_nx;
            end
        end
    end

    // The last stage's operand copies and the sub flag are carried for
    // alignment/debug; nothing downstream consumes them.
    logic w_unused_regs;
    assign w_unused_regs = ^{r_sub, r_a[STAGES-1], r_b[STAGES-1]};

    assign out_valid = r_v[STAGES-1];
    assign sum       = r_s[STAGES-1];
    assign cout      = r_c[STAGES-1];
    assign ovf       = r_ovf;

endmodule : cla_pipe_adder

// File: tb/tb_cla_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_cla_pipe_adder
//   Self-checking bench for cla_pipe_adder (WIDTH=32, GPS=2, 4 stages).
//   Expected results come from an integer-arithmetic model; a queue of
//   expected results tracks ordering through stalls and resets.
// ---------------------------------------------------------------------------
module tb_cla_pipe_adder;

    localparam int     W      = 32;
    localparam int     STAGES = 4;
    localparam longint S_MAX  = 64'sd2147483647;
    localparam longint S_MIN  = -S_MAX - 64'sd1;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    cla_pipe_adder #(.WIDTH(W), .GPS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_out    = 0;
    logic [33:0] q_exp[$];
    logic        smp_in_ready;
    logic        smp_out_valid;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks += 1;
        assert (obs === exp) n_pass += 1;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: plain signed/unsigned integer arithmetic, packed {cout, ovf, sum}.
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s);
        longint      sx;
        longint      sy;
        longint      sr;
        logic [32:0] wide;
        logic        co;
        logic        ov;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (s) begin
            sr   = sx - sy;
            wide = {1'b0, x} - {1'b0, y};
            co   = (x >= y);
        end else begin
            sr   = sx + sy + longint'(ci);
            wide = {1'b0, x} + {1'b0, y} + 33'(ci);
            co   = wide[32];
        end
        ov = (sr > S_MAX) || (sr < S_MIN);
        return {co, ov, wide[31:0]};
    endfunction

    // One clock: sample handshakes at negedge, score, then step past posedge.
    task automatic cycle(output bit acc);
        logic [33:0] exp_v;
        bit          xfer;
        @(negedge clk);
        smp_in_ready  = in_ready;
        smp_out_valid = out_valid;
        acc  = in_valid && in_ready;
        xfer = out_valid && out_ready;
        if (xfer) begin
            n_out += 1;
            if (q_exp.size() == 0) begin
                check("unexpected_result", {63'd0, out_valid}, 64'd0);
            end else begin
                exp_v = q_exp.pop_front();
                check("result", {30'd0, cout, ovf, sum}, {30'd0, exp_v});
            end
        end else if (out_valid && q_exp.size() > 0) begin
            check("stall_hold", {30'd0, cout, ovf, sum}, {30'd0, q_exp[0]});
        end
        if (acc) q_exp.push_back(model(a, b, cin, sub));
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] x, input logic [31:0] y,
                         input logic ci, input logic s);
        a = x; b = y; cin = ci; sub = s; in_valid = 1'b1;
    endtask

    task automatic drive_rand();
        logic [31:0] x;
        logic [31:0] y;
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 7))
            0:       y = ~x;
            1:       x = 32'hFFFF_FFFF;
            2:       y = x;
            default: ;
        endcase
        drive(x, y, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic drain(input string tag);
        bit acc;
        for (int i = 0; i < 50 && q_exp.size() > 0; i++) cycle(acc);
        check(tag, 64'(q_exp.size()), 64'd0);
    endtask

    // Single beat: measure edges from presentation to out_valid, then drain.
    task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                          input logic ci, input logic s);
        bit acc;
        int n;
        out_ready = 1'b1;
        drive(x, y, ci, s);
        cycle(acc);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 20) begin
            cycle(acc);
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(STAGES));
        drain({tag, "_drain"});
    endtask

    initial begin
        bit acc;
        int idx;
        int n;
        int n_stall;
        int out_base;
        int ov_cnt;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_sum",       {32'd0, sum},       64'd0);
        check("rst_cout",      {63'd0, cout},      64'd0);
        check("rst_ovf",       {63'd0, ovf},       64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(acc);
        check("post_rst_in_ready", {63'd0, smp_in_ready}, 64'd1);

        // Directed corner beats.
        single("add_wrap",  32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0);
        single("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        single("sub_neg",   32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        single("carry_all", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
        // The model above is independent, but pin the plan's literal values too.
        check("lit_sub_neg", {30'd0, model(32'd5, 32'd7, 1'b0, 1'b1)},
              {30'd0, 1'b0, 1'b0, 32'hFFFF_FFFE});

        // Backpressure: 8 beats, out_ready low in cycles 3..9.
        idx = 0;
        out_base = n_out;
        drive_rand();
        for (int cyc = 0; cyc < 80 && (idx < 8 || q_exp.size() > 0); cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 9);
            cycle(acc);
            if (acc) begin
                idx++;
                if (idx < 8) drive_rand();
                else in_valid = 1'b0;
            end
            if (cyc == 3) check("bp_in_ready_c3", {63'd0, smp_in_ready}, 64'd1);
            if (cyc == 4) check("bp_in_ready_c4", {63'd0, smp_in_ready}, 64'd0);
            if (cyc == 9) check("bp_held_beats", 64'(idx), 64'd4);
        end
        check("bp_count", 64'(n_out - out_base), 64'd8);
        check("bp_empty", 64'(q_exp.size()), 64'd0);

        // Full throughput: 1000 random beats.
        out_ready = 1'b1;
        idx = 0; n = 0; n_stall = 0;
        out_base = n_out;
        drive_rand();
        while ((idx < 1000 || q_exp.size() > 0) && n < 1200) begin
            cycle(acc);
            n++;
            if (in_valid && !acc) n_stall++;
            if (acc) begin
                idx++;
                if (idx < 1000) drive_rand();
                else in_valid = 1'b0;
            end
        end
        check("tp_stalls", 64'(n_stall), 64'd0);
        check("tp_cycles", 64'(n), 64'(1000 + STAGES));
        check("tp_count",  64'(n_out - out_base), 64'd1000);

        // Asynchronous reset with three beats in flight.
        out_ready = 1'b0;
        drive(32'h8000_0001, 32'h8000_0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(acc);
        in_valid = 1'b0;
        cycle(acc);
        cycle(acc);
        check("pre_rst_out_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", {63'd0, out_valid}, 64'd0);
        check("arst_sum",       {32'd0, sum},       64'd0);
        check("arst_cout",      {63'd0, cout},      64'd0);
        check("arst_ovf",       {63'd0, ovf},       64'd0);
        q_exp.delete();
        @(posedge clk);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        ov_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(acc);
            if (smp_out_valid) ov_cnt++;
        end
        check("post_arst_no_stale", 64'(ov_cnt), 64'd0);

        // Pipeline still works after the mid-stream reset.
        single("post_arst_beat", 32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cla_pipe_adder
